bp_cache_dma_arbiter: RTL and testbench

// - N:1 round-robin arbiter and sequencer letting several bsg_cache-style DMA masters
//   (L2 of bp_unicore, accelerator caches) share one bsg_cache_to_axi engine (num_cache_p=1).
// - Grants one requester per DMA transaction and locks the shared data channels to it until the

---
 rtl/bp_cache_dma_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_bp_cache_dma_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cache_dma_arbiter.sv
// rtl/bp_cache_dma_arbiter.sv - round-robin N:1 DMA arbiter sharing one cache-to-axi engine
// One requester owns the data channels for a full block of beats after its packet is accepted.
module bp_cache_dma_arbiter #(
  parameter int num_req_p             = 2,
  parameter int addr_width_p          = 32,
  parameter int data_width_p          = 64,
  parameter int block_size_in_words_p = 8,
  localparam int pkt_width_lp         = 1 + addr_width_p
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,

  input  logic [num_req_p*pkt_width_lp-1:0] req_dma_pkt_i,
  input  logic [num_req_p-1:0]              req_dma_pkt_v_i,
  output logic [num_req_p-1:0]              req_dma_pkt_yumi_o,

  output logic [data_width_p-1:0]           req_dma_data_o,
  output logic [num_req_p-1:0]              req_dma_data_v_o,
  input  logic [num_req_p-1:0]              req_dma_data_ready_and_i,

  input  logic [num_req_p*data_width_p-1:0] req_dma_data_i,
  input  logic [num_req_p-1:0]              req_dma_data_v_i,
  output logic [num_req_p-1:0]              req_dma_data_yumi_o,

  output logic [pkt_width_lp-1:0]           dma_pkt_o,
  output logic                              dma_pkt_v_o,
  input  logic                              dma_pkt_yumi_i,

  input  logic [data_width_p-1:0]           dma_data_i,
  input  logic                              dma_data_v_i,
  output logic                              dma_data_ready_and_o,

  output logic [data_width_p-1:0]           dma_data_o,
  output logic                              dma_data_v_o,
  input  logic                              dma_data_yumi_i
);

  localparam int idx_w_lp = $clog2(num_req_p);
  localparam int cnt_w_lp = $clog2(block_size_in_words_p);
  localparam logic [idx_w_lp-1:0] last_req_lp  = idx_w_lp'(num_req_p - 1);
  localparam logic [cnt_w_lp-1:0] last_beat_lp = cnt_w_lp'(block_size_in_words_p - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    RD_DATA = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [idx_w_lp-1:0]   rr_ptr_q, rr_ptr_d;
  logic [idx_w_lp-1:0]   owner_q, owner_d;
  logic [cnt_w_lp-1:0]   beat_cnt_q, beat_cnt_d;
  logic                  lock_q, lock_d;
  logic [idx_w_lp-1:0]   grant_q, grant_d;

  logic [idx_w_lp-1:0]   arb_grant;
  logic [idx_w_lp-1:0]   arb_cand;
  logic                  arb_found;
  logic [idx_w_lp-1:0]   grant;
  logic                  pkt_v;
  logic                  beat_done;

  logic [pkt_width_lp-1:0] pkt_arr   [num_req_p];
  logic [data_width_p-1:0] wdata_arr [num_req_p];

  for (genvar g = 0; g < num_req_p; g++) begin : g_slice
    assign pkt_arr[g]   = req_dma_pkt_i[g*pkt_width_lp +: pkt_width_lp];
    assign wdata_arr[g] = req_dma_data_i[g*data_width_p +: data_width_p];
  end

  function automatic logic [idx_w_lp-1:0] next_idx(input logic [idx_w_lp-1:0] i);
    return (i == last_req_lp) ? '0 : i + idx_w_lp'(1);
  endfunction

  // Scan upward from rr_ptr with wrap; the first valid requester wins.
  always_comb begin
    arb_grant = rr_ptr_q;
    arb_cand  = rr_ptr_q;
    arb_found = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      if (!arb_found && req_dma_pkt_v_i[arb_cand]) begin
        arb_grant = arb_cand;
        arb_found = 1'b1;
      end
      arb_cand = next_idx(arb_cand);
    end
  end

  // Once a packet has been shown to the engine, later arrivals cannot steal it.
  assign grant = lock_q ? grant_q : arb_grant;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    lock_d     = lock_q;
    grant_d    = grant_q;
    pkt_v      = 1'b0;
    beat_done  = 1'b0;

    dma_pkt_o            = pkt_arr[grant];
    dma_pkt_v_o          = 1'b0;
    req_dma_pkt_yumi_o   = '0;
    dma_data_o           = wdata_arr[owner_q];
    dma_data_v_o         = 1'b0;
    req_dma_data_yumi_o  = '0;
    req_dma_data_o       = dma_data_i;
    req_dma_data_v_o     = '0;
    dma_data_ready_and_o = 1'b0;

    case (state_q)
      IDLE: begin
        pkt_v       = lock_q ? req_dma_pkt_v_i[grant_q] : |req_dma_pkt_v_i;
        dma_pkt_v_o = pkt_v;
        if (pkt_v) begin
          if (dma_pkt_yumi_i) begin
            req_dma_pkt_yumi_o[grant] = 1'b1;
            owner_d    = grant;
            rr_ptr_d   = next_idx(grant);
            beat_cnt_d = '0;
            lock_d     = 1'b0;
            state_d    = pkt_arr[grant][pkt_width_lp-1] ? WR_DATA : RD_DATA;
          end else begin
            lock_d  = 1'b1;
            grant_d = grant;
          end
        end
      end
      WR_DATA: begin
        dma_data_v_o = req_dma_data_v_i[owner_q];
        if (dma_data_yumi_i && req_dma_data_v_i[owner_q]) begin
          req_dma_data_yumi_o[owner_q] = 1'b1;
          beat_done = 1'b1;
        end
      end
      RD_DATA: begin
        req_dma_data_v_o[owner_q] = dma_data_v_i;
        dma_data_ready_and_o      = req_dma_data_ready_and_i[owner_q];
        beat_done = dma_data_v_i & req_dma_data_ready_and_i[owner_q];
      end
      default: state_d = IDLE;
    endcase

    if (beat_done) begin
      if (beat_cnt_q == last_beat_lp) begin
        beat_cnt_d = '0;
        state_d    = IDLE;
      end else begin
        beat_cnt_d = beat_cnt_q + cnt_w_lp'(1);
      end
    end

    if (!reset_n_i) begin
      dma_pkt_v_o          = 1'b0;
      req_dma_pkt_yumi_o   = '0;
      dma_data_v_o         = 1'b0;
      req_dma_data_yumi_o  = '0;
      req_dma_data_v_o     = '0;
      dma_data_ready_and_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      lock_q     <= 1'b0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      lock_q     <= lock_d;
      grant_q    <= grant_d;
    end
  end

  // Protocol checks: a presented packet must be held, engine read data only in RD_DATA.
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      if (state_q == IDLE && lock_q) assert (req_dma_pkt_v_i[grant_q]);
      if (state_q != RD_DATA) assert (!dma_data_v_i);
    end
  end

endmodule

// File: tb/tb_bp_cache_dma_arbiter.sv
// tb/tb_bp_cache_dma_arbiter.sv - scoreboard bench for bp_cache_dma_arbiter
// Requesters and engine are modelled here; expected packets and beats are queued at launch.
module tb_bp_cache_dma_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int PW = AW + 1;
  localparam int BS = 8;

  logic              clk;
  logic              reset_n_i;
  logic [NR*PW-1:0]  req_dma_pkt_i;
  logic [NR-1:0]     req_dma_pkt_v_i;
  logic [NR-1:0]     req_dma_pkt_yumi_o;
  logic [DW-1:0]     req_dma_data_o;
  logic [NR-1:0]     req_dma_data_v_o;
  logic [NR-1:0]     req_dma_data_ready_and_i;
  logic [NR*DW-1:0]  req_dma_data_i;
  logic [NR-1:0]     req_dma_data_v_i;
  logic [NR-1:0]     req_dma_data_yumi_o;
  logic [PW-1:0]     dma_pkt_o;
  logic              dma_pkt_v_o;
  logic              dma_pkt_yumi_i;
  logic [DW-1:0]     dma_data_i;
  logic              dma_data_v_i;
  logic              dma_data_ready_and_o;
  logic [DW-1:0]     dma_data_o;
  logic              dma_data_v_o;
  logic              dma_data_yumi_i;

  bp_cache_dma_arbiter dut (
    .clk_i                    (clk),
    .reset_n_i                (reset_n_i),
    .req_dma_pkt_i            (req_dma_pkt_i),
    .req_dma_pkt_v_i          (req_dma_pkt_v_i),
    .req_dma_pkt_yumi_o       (req_dma_pkt_yumi_o),
    .req_dma_data_o           (req_dma_data_o),
    .req_dma_data_v_o         (req_dma_data_v_o),
    .req_dma_data_ready_and_i (req_dma_data_ready_and_i),
    .req_dma_data_i           (req_dma_data_i),
    .req_dma_data_v_i         (req_dma_data_v_i),
    .req_dma_data_yumi_o      (req_dma_data_yumi_o),
    .dma_pkt_o                (dma_pkt_o),
    .dma_pkt_v_o              (dma_pkt_v_o),
    .dma_pkt_yumi_i           (dma_pkt_yumi_i),
    .dma_data_i               (dma_data_i),
    .dma_data_v_i             (dma_data_v_i),
    .dma_data_ready_and_o     (dma_data_ready_and_o),
    .dma_data_o               (dma_data_o),
    .dma_data_v_o             (dma_data_v_o),
    .dma_data_yumi_i          (dma_data_yumi_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int            who;
    logic [PW-1:0] pkt;
  } pexp_t;

  pexp_t         pexp [$];
  logic [DW-1:0] wexp [$];
  logic [DW-1:0] rexp [$];

  int total;
  int bad;

  logic [NR-1:0] rq_pend;
  logic [PW-1:0] rq_pkt   [NR];
  logic [NR-1:0] rq_wv;
  logic [DW-1:0] rq_wbase [NR];
  int            rq_wbeat [NR];
  logic [DW-1:0] rq_rbase [NR];
  logic [NR-1:0] rq_rready;
  logic [NR-1:0] rq_tog;

  logic          pkt_yumi_en;
  int            cur_who;
  int            wr_left;
  int            rd_left;
  logic [DW-1:0] rd_base;

  function automatic logic [NR-1:0] onehot(input int w);
    return NR'(1 << w);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    rq_pend = '0; rq_wv = '0; rq_rready = '0; rq_tog = '0;
    for (int i = 0; i < NR; i++) begin
      rq_pkt[i] = '0; rq_wbase[i] = '0; rq_wbeat[i] = 0; rq_rbase[i] = '0;
    end
    pexp.delete(); wexp.delete(); rexp.delete();
    pkt_yumi_en = 1'b1; cur_who = 0; wr_left = 0; rd_left = 0; rd_base = '0;
  endtask

  task automatic launch_write(input int r, input logic [AW-1:0] a, input logic [DW-1:0] b);
    pexp_t e;
    rq_pend[r] = 1'b1; rq_pkt[r] = {1'b1, a}; rq_wv[r] = 1'b1;
    rq_wbase[r] = b; rq_wbeat[r] = 0;
    e.who = r; e.pkt = {1'b1, a};
    pexp.push_back(e);
    for (int k = 0; k < BS; k++) wexp.push_back(b + 64'(k));
  endtask

  task automatic launch_read(input int r, input logic [AW-1:0] a, input logic [DW-1:0] b);
    pexp_t e;
    rq_pend[r] = 1'b1; rq_pkt[r] = {1'b0, a}; rq_rbase[r] = b;
    e.who = r; e.pkt = {1'b0, a};
    pexp.push_back(e);
    for (int k = 0; k < BS; k++) rexp.push_back(b + 64'(k));
  endtask

  // Drive one cycle from the model, compare outputs, then advance the model past the edge.
  task automatic cycle();
    logic  exp_pv, take, wbeat_hs, rbeat_hs;
    pexp_t hp;
    for (int i = 0; i < NR; i++) begin
      req_dma_pkt_v_i[i]            = rq_pend[i];
      req_dma_pkt_i[i*PW +: PW]     = rq_pkt[i];
      req_dma_data_v_i[i]           = rq_wv[i];
      req_dma_data_i[i*DW +: DW]    = rq_wbase[i] + 64'(rq_wbeat[i]);
      req_dma_data_ready_and_i[i]   = rq_rready[i];
    end
    dma_data_v_i    = (rd_left > 0);
    dma_data_i      = rd_base + 64'(BS - rd_left);
    dma_data_yumi_i = (wr_left > 0);
    exp_pv          = (wr_left == 0) && (rd_left == 0) && (rq_pend != '0);
    take            = exp_pv && pkt_yumi_en;
    dma_pkt_yumi_i  = take;
    hp              = '0;
    if (pexp.size() > 0) hp = pexp[0];
    #1;
    check("pkt_v", 64'(dma_pkt_v_o), 64'(exp_pv));
    if (exp_pv && pexp.size() > 0) begin
      check("pkt_data", 64'(dma_pkt_o), 64'(hp.pkt));
      check("pkt_yumi", 64'(req_dma_pkt_yumi_o), 64'(take ? onehot(hp.who) : NR'(0)));
    end else begin
      check("pkt_yumi_idle", 64'(req_dma_pkt_yumi_o), 64'(0));
    end
    wbeat_hs = (wr_left > 0) && rq_wv[cur_who];
    check("wr_v", 64'(dma_data_v_o), 64'(wbeat_hs));
    check("wr_yumi", 64'(req_dma_data_yumi_o), 64'(wbeat_hs ? onehot(cur_who) : NR'(0)));
    if (wbeat_hs && wexp.size() > 0) check("wr_data", dma_data_o, wexp[0]);
    rbeat_hs = (rd_left > 0) && rq_rready[cur_who];
    check("rd_v", 64'(req_dma_data_v_o), 64'((rd_left > 0) ? onehot(cur_who) : NR'(0)));
    check("rd_ready", 64'(dma_data_ready_and_o), 64'(rbeat_hs));
    if (rbeat_hs && rexp.size() > 0) check("rd_data", req_dma_data_o, rexp[0]);
    @(posedge clk); #1;
    if (wbeat_hs) begin
      if (wexp.size() > 0) void'(wexp.pop_front());
      rq_wbeat[cur_who]++;
      wr_left--;
      if (wr_left == 0) begin rq_wv[cur_who] = 1'b0; rq_wbeat[cur_who] = 0; end
    end
    if (rbeat_hs) begin
      if (rexp.size() > 0) void'(rexp.pop_front());
      rd_left--;
    end
    if (take && pexp.size() > 0) begin
      hp = pexp.pop_front();
      rq_pend[hp.who] = 1'b0;
      cur_who = hp.who;
      if (hp.pkt[PW-1]) wr_left = BS;
      else begin rd_left = BS; rd_base = rq_rbase[hp.who]; end
    end
    for (int i = 0; i < NR; i++) if (rq_tog[i]) rq_rready[i] = ~rq_rready[i];
  endtask

  task automatic run(input int budget);
    for (int n = 0; n < budget; n++) begin
      if (pexp.size() == 0 && wexp.size() == 0 && rexp.size() == 0 &&
          wr_left == 0 && rd_left == 0 && rq_pend == '0) break;
      cycle();
    end
  endtask

  // Busy inputs while reset is low: every handshake output must still be quiet.
  task automatic rst_check(input string tag);
    req_dma_pkt_v_i = '1; req_dma_data_v_i = '1; req_dma_data_ready_and_i = '1;
    dma_data_v_i = 1'b1; dma_pkt_yumi_i = 1'b1; dma_data_yumi_i = 1'b1;
    #1;
    check(tag, 64'({dma_pkt_v_o, req_dma_pkt_yumi_o, req_dma_data_v_o,
                    req_dma_data_yumi_o, dma_data_v_o, dma_data_ready_and_o}), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0;
    clear_model();
    reset_n_i = 1'b0;
    req_dma_pkt_i = '0; req_dma_pkt_v_i = '0; req_dma_data_ready_and_i = '0;
    req_dma_data_i = '0; req_dma_data_v_i = '0; dma_pkt_yumi_i = 1'b0;
    dma_data_i = '0; dma_data_v_i = 1'b0; dma_data_yumi_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_check("reset_outputs");
    @(posedge clk); #1;
    reset_n_i = 1'b1;

    // Simultaneous writes from rr_ptr=0: req0 first; req1's early write data is held off.
    launch_write(0, 32'h0000_2000, 64'hA000_0000_0000_0000);
    launch_write(1, 32'h0000_3000, 64'hB100_0000_0000_0000);
    run(100);

    // Single read by req0, engine returns beats 0..7.
    rq_rready[0] = 1'b1;
    launch_read(0, 32'h0000_1000, 64'h0);
    run(100);

    // rr_ptr now 1: req1 read (ready toggling) wins over req0 write.
    rq_rready[1] = 1'b0; rq_tog[1] = 1'b1;
    launch_read(1, 32'h0000_5000, 64'hC200_0000_0000_0010);
    launch_write(0, 32'h0000_4000, 64'hA300_0000_0000_0020);
    run(100);
    rq_tog[1] = 1'b0; rq_rready[1] = 1'b1;

    // Engine stalls the packet 5 cycles; req1 arrives meanwhile but req0 stays presented.
    pkt_yumi_en = 1'b0;
    launch_read(0, 32'h0000_9000, 64'hD400_0000_0000_0000);
    cycle();
    launch_write(1, 32'h0000_A000, 64'hE500_0000_0000_0000);
    repeat (4) cycle();
    pkt_yumi_en = 1'b1;
    run(100);

    // Reset in the middle of a write, after three beats.
    launch_write(0, 32'h0000_6000, 64'hF600_0000_0000_0000);
    for (int n = 0; n < 40 && wr_left != BS - 3; n++) cycle();
    reset_n_i = 1'b0;
    rst_check("reset_mid_write");
    @(posedge clk); #1;
    rst_check("reset_after_edge");
    reset_n_i = 1'b1;
    clear_model();
    rq_rready = '1;
    launch_read(0, 32'h0000_7000, 64'h1700_0000_0000_0000);
    launch_read(1, 32'h0000_8000, 64'h2800_0000_0000_0000);
    run(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
